// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, owner encoding and stall-counter width for dmem_arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int STALL_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick between the CPU and debug requesters
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req_cpu,
    input  logic req_dbg,
    input  logic last_grant,
    output logic any,
    output logic win
);

    assign any = req_cpu | req_dbg;
    assign win = (req_cpu && req_dbg) ? ~last_grant : (req_dbg ? OWN_DBG : OWN_CPU);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between a CPU and a debug requester (optional DMEM_ARB_STALL_CNT_EN adds cpu_stall_cnt)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] cpu_stall_cnt
`endif
);

    state_t        state, state_d;
    logic          owner, owner_d;
    logic          last_grant, last_d;
    logic          rd, rd_d;
    logic          armed;
    logic          any, win;
    logic          sel_req, sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 u_arb (
        .req_cpu   (cpu_req),
        .req_dbg   (dbg_req),
        .last_grant(last_grant),
        .any       (any),
        .win       (win)
    );

    assign sel_req   = owner == OWN_DBG ? dbg_req   : cpu_req;
    assign sel_we    = owner == OWN_DBG ? dbg_we    : cpu_we;
    assign sel_addr  = owner == OWN_DBG ? dbg_addr  : cpu_addr;
    assign sel_wdata = owner == OWN_DBG ? dbg_wdata : cpu_wdata;

    // State and arbitration history; armed holds off arbitration for the first cycle after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_DBG;
            rd         <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_grant <= last_d;
            rd         <= rd_d;
            armed      <= 1'b1;
        end
    end

    // Next state and all outputs; an owner that dropped req by its ISSUE cycle gets no access
    always_comb begin
        state_d    = state;
        owner_d    = owner;
        last_d     = last_grant;
        rd_d       = rd;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rdata  = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (armed && any) begin
                    owner_d = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_req) begin
                    mem_en    = 1'b1;
                    mem_we    = sel_we;
                    mem_addr  = sel_addr;
                    mem_wdata = sel_wdata;
                    cpu_gnt   = owner == OWN_CPU;
                    dbg_gnt   = owner == OWN_DBG;
                    last_d    = owner;
                    rd_d      = !sel_we;
                    state_d   = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                cpu_rvalid = rd && owner == OWN_CPU;
                dbg_rvalid = rd && owner == OWN_DBG;
                cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
                dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
                owner_d    = any ? win : owner;
                state_d    = any ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DMEM_ARB_STALL_CNT_EN
    // Cycles the CPU spends requesting without a grant, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cpu_stall_cnt <= '0;
        else if (cpu_req && !cpu_gnt && cpu_stall_cnt != '1)
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
`endif

endmodule
